// File: rtl/fdiv_ctrl.sv
// Run-control and rate scheduler for the display clock divider.
// A programmable divisor sets the tick period to div_q+1 cycles. The divide
// counter runs freely (RUN) or for exactly one period (STEP). Each period end
// raises a one-cycle tick, toggles div_clk and advances the tick count.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | counter parked at 0, divisor loads accepted, tick low
// RUN   | free-running divide, tick every div_q+1 cycles until stop
// STEP  | one divide period, returns to IDLE on the edge raising tick
module fdiv_ctrl #(
    parameter int               WIDTH   = 24,
    parameter int               CNT_W   = 16,
    parameter logic [WIDTH-1:0] DEF_DIV = WIDTH'(24'hFFFFFF)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    output logic             tick,
    output logic             div_clk,
    output logic             busy,
    output logic [CNT_W-1:0] tick_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] div_q, div_nxt;
    logic             tick_nxt;
    logic             dclk_nxt;
    logic [CNT_W-1:0] tcnt_nxt;

    // Handshake and busy flag follow the state directly.
    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // State and datapath registers; reset restores the default divisor.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            cnt      <= '0;
            div_q    <= DEF_DIV;
            tick     <= 1'b0;
            div_clk  <= 1'b0;
            tick_cnt <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            div_q    <= div_nxt;
            tick     <= tick_nxt;
            div_clk  <= dclk_nxt;
            tick_cnt <= tcnt_nxt;
        end
    end

    // Next-state and datapath update; control priority is stop > start > step.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        div_nxt   = div_q;
        tick_nxt  = 1'b0;
        dclk_nxt  = div_clk;
        tcnt_nxt  = tick_cnt;

        // A load coinciding with start/step lands together with the
        // counter clear, so the new divisor governs that run.
        if (cfg_valid && cfg_ready) begin
            div_nxt = cfg_div;
        end

        case (state)
            IDLE: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (start) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    tcnt_nxt  = '0;
                end else if (step) begin
                    state_nxt = STEP;
                    cnt_nxt   = '0;
                end
            end
            RUN, STEP: begin
                if (stop) begin
                    // Abort wins over a period end on the same edge.
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == div_q) begin
                    cnt_nxt  = '0;
                    tick_nxt = 1'b1;
                    dclk_nxt = ~div_clk;
                    tcnt_nxt = tick_cnt + CNT_W'(1);
                    if (state == STEP) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + WIDTH'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_fdiv_ctrl.sv
// Bench for fdiv_ctrl: stimulus pushes expected ticks (cycle, count, div_clk
// level) into a scoreboard; a negedge monitor pops one per observed tick.
module tb_fdiv_ctrl;

    localparam int WIDTH = 24;
    localparam int CNT_W = 4;

    typedef struct {
        int         cyc;
        logic [3:0] cnt;
        logic       dclk;
    } exp_t;

    logic             clk = 1'b0;
    logic             nrst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_div;
    logic             start;
    logic             stop;
    logic             step;
    logic             tick;
    logic             div_clk;
    logic             busy;
    logic [CNT_W-1:0] tick_cnt;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    fdiv_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DEF_DIV(24'd9)) dut (
        .clk(clk), .nrst(nrst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_div(cfg_div), .start(start), .stop(stop), .step(step),
        .tick(tick), .div_clk(div_clk), .busy(busy), .tick_cnt(tick_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input int cnt, input logic d);
        exp_t e;
        e.cyc  = c;
        e.cnt  = 4'(cnt);
        e.dclk = d;
        sb.push_back(e);
    endtask

    // Monitor: every observed tick must match the oldest expected one.
    always @(negedge clk) begin
        if (nrst && tick) begin
            if (sb.size() == 0) begin
                chk("tick_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("tick_cycle", cyc, e.cyc);
                chk("tick_cnt_at_tick", int'(tick_cnt), int'(e.cnt));
                chk("div_clk_at_tick", int'(div_clk), int'(e.dclk));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic d;
        nrst = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        start = 1'b0; stop = 1'b0; step = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tick", int'(tick), 0);
        chk("rst_div_clk", int'(div_clk), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_tick_cnt", int'(tick_cnt), 0);
        nrst = 1'b1;
        next();

        // Step with the reset divisor (9): one tick 10 cycles after the edge.
        step = 1'b1; c0 = cyc + 1;
        push(c0 + 10, 1, 1'b1);
        next();
        step = 1'b0;
        chk("step_busy", int'(busy), 1);
        chk("step_cfg_ready", int'(cfg_ready), 0);
        while (cyc < c0 + 11) next();
        chk("step_done_busy", int'(busy), 0);
        chk("step_tick_cnt", int'(tick_cnt), 1);

        // Load 3 then start: ticks every 4 cycles, tick_cnt restarts at 0.
        cfg_valid = 1'b1; cfg_div = 24'd3;
        next();
        cfg_valid = 1'b0;
        start = 1'b1; c0 = cyc + 1;
        d = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            d = ~d;
            push(c0 + 4 * k, k, d);
        end
        next();
        start = 1'b0;
        chk("run_busy", int'(busy), 1);
        while (cyc < c0 + 20) next();
        @(negedge clk);
        chk("run_tick_cnt_20", int'(tick_cnt), 5);

        // Load request and a second start while running: both ignored.
        next();
        cfg_valid = 1'b1; cfg_div = 24'd7; start = 1'b1;
        #1;
        chk("run_cfg_ready", int'(cfg_ready), 0);
        next();
        start = 1'b0;
        // stop+start on the edge where cnt == div_q: idle, no tick.
        while (cyc < c0 + 31) next();
        stop = 1'b1; start = 1'b1;
        next();
        stop = 1'b0; start = 1'b0;
        chk("stop_busy", int'(busy), 0);
        chk("stop_tick", int'(tick), 0);
        chk("stop_cfg_ready", int'(cfg_ready), 1);
        chk("stop_tick_cnt", int'(tick_cnt), 7);
        chk("stop_div_clk", int'(div_clk), 0);
        next();
        // Held request was accepted on the first IDLE edge: step uses 7.
        cfg_valid = 1'b0;
        step = 1'b1; c0 = cyc + 1;
        push(c0 + 8, 8, 1'b1);
        next();
        step = 1'b0;
        while (cyc < c0 + 9) next();
        chk("step7_busy", int'(busy), 0);
        chk("step7_tick_cnt", int'(tick_cnt), 8);

        // start+step with load of 0: RUN, tick every cycle, tick_cnt wraps.
        cfg_valid = 1'b1; cfg_div = 24'd0; start = 1'b1; step = 1'b1;
        c0 = cyc + 1;
        d = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            d = ~d;
            push(c0 + k, k % 16, d);
        end
        next();
        cfg_valid = 1'b0; start = 1'b0; step = 1'b0;
        chk("div0_busy", int'(busy), 1);
        while (cyc < c0 + 20) next();
        stop = 1'b1;
        next();
        stop = 1'b0;
        chk("div0_stop_busy", int'(busy), 0);
        chk("div0_stop_tick", int'(tick), 0);
        chk("div0_tick_cnt_wrap", int'(tick_cnt), 4);
        chk("div0_div_clk", int'(div_clk), 1);

        // Divisor 5 run, then async reset right after the second tick.
        cfg_valid = 1'b1; cfg_div = 24'd5; start = 1'b1;
        c0 = cyc + 1;
        push(c0 + 6, 1, 1'b0);
        next();
        cfg_valid = 1'b0; start = 1'b0;
        while (cyc < c0 + 12) next();
        chk("pre_rst_tick", int'(tick), 1);
        chk("pre_rst_div_clk", int'(div_clk), 1);
        chk("pre_rst_tick_cnt", int'(tick_cnt), 2);
        #2;
        nrst = 1'b0;
        #1;
        chk("async_rst_tick", int'(tick), 0);
        chk("async_rst_div_clk", int'(div_clk), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_cfg_ready", int'(cfg_ready), 1);
        chk("async_rst_tick_cnt", int'(tick_cnt), 0);
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        next();
        chk("sb_leftover", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
